// File: rtl/utf8_pkg.sv
// Shared UTF-8 decoding types, code-point constants and the strict lead-byte table.
package utf8_pkg;

    localparam logic [20:0] CP_REPLACEMENT = 21'h00FFFD;
    localparam logic [20:0] CP_MAX         = 21'h10FFFF;
    localparam logic [20:0] SURR_LO        = 21'h00D800;
    localparam logic [20:0] SURR_HI        = 21'h00DFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_C1   = 2'd1,
        ST_C2   = 2'd2,
        ST_C3   = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] len;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       invalid;
    } lead_t;

    // lo/hi bound the first continuation byte; this is where overlongs,
    // surrogates and values above U+10FFFF are rejected.
    function automatic lead_t lead_class(input logic [7:0] b, input logic allow_surr);
        lead_t r;
        r.len     = 3'd1;
        r.lo      = 8'h80;
        r.hi      = 8'hBF;
        r.invalid = 1'b0;
        if (b < 8'h80) begin
            r.len = 3'd1;
        end else if (b < 8'hC2) begin
            r.invalid = 1'b1;
        end else if (b <= 8'hDF) begin
            r.len = 3'd2;
        end else if (b == 8'hE0) begin
            r.len = 3'd3;
            r.lo  = 8'hA0;
        end else if (b == 8'hED) begin
            r.len = 3'd3;
            r.hi  = allow_surr ? 8'hBF : 8'h9F;
        end else if (b <= 8'hEF) begin
            r.len = 3'd3;
        end else if (b == 8'hF0) begin
            r.len = 3'd4;
            r.lo  = 8'h90;
        end else if (b <= 8'hF3) begin
            r.len = 3'd4;
        end else if (b == 8'hF4) begin
            r.len = 3'd4;
            r.hi  = 8'h8F;
        end else begin
            r.invalid = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/utf8_lead_classify.sv
// Combinational lead-byte classifier: sequence length and first-continuation bounds.
module utf8_lead_classify
    import utf8_pkg::*;
#(
    parameter bit ALLOW_SURR = 1'b0
) (
    input  logic [7:0] i_byte,
    output lead_t      o_class
);

    assign o_class = lead_class(i_byte, ALLOW_SURR);

endmodule

// File: rtl/utf8_stream_decoder.sv
// Strict streaming UTF-8 decoder: one byte in per cycle, one scalar or error token out.
//   state   | meaning
//   ST_IDLE | expecting a lead byte
//   ST_C1   | one continuation byte still required
//   ST_C2   | two continuation bytes still required
//   ST_C3   | three continuation bytes still required
module utf8_stream_decoder
    import utf8_pkg::*;
#(
    parameter bit REPLACE    = 1'b1,
    parameter bit ALLOW_SURR = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [20:0]      out_cp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err,
    output logic             out_trunc,
    output logic             out_last,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [20:0] ERR_CP = REPLACE ? CP_REPLACEMENT : 21'd0;

    state_t           r_state, w_state_nxt;
    logic [14:0]      r_acc, w_acc_nxt;
    logic [7:0]       r_lo, r_hi, w_lo_nxt, w_hi_nxt;
    logic             r_hold_v, r_hold_last;
    logic [7:0]       r_hold_byte;
    logic             r_out_valid, r_out_err, r_out_trunc, r_out_last;
    logic [20:0]      r_out_cp;
    logic [CNT_W-1:0] r_err_count;

    logic        w_free, w_go, w_src_v, w_last, w_in_range, w_cp_legal, w_hold_set;
    logic [7:0]  w_byte;
    logic [20:0] w_cp_full;
    logic        w_emit, w_emit_err, w_emit_trunc, w_emit_last;
    logic [20:0] w_emit_cp;
    lead_t       w_lead;

    utf8_lead_classify #(.ALLOW_SURR(ALLOW_SURR)) u_lead (
        .i_byte  (w_byte),
        .o_class (w_lead)
    );

    assign w_free     = !r_out_valid | out_ready;
    assign in_ready   = w_free & !r_hold_v;
    assign w_byte     = r_hold_v ? r_hold_byte : in_data;
    assign w_last     = r_hold_v ? r_hold_last : in_last;
    assign w_src_v    = r_hold_v | in_valid;
    assign w_go       = w_free & w_src_v;
    assign w_in_range = (w_byte >= r_lo) && (w_byte <= r_hi);
    assign w_cp_full  = {r_acc, w_byte[5:0]};
    // Unreachable with the bounds table; kept as a guard on the emitted scalar.
    assign w_cp_legal = (w_cp_full <= CP_MAX) &&
                        (ALLOW_SURR || (w_cp_full < SURR_LO) || (w_cp_full > SURR_HI));

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_emit       = 1'b0;
        w_emit_cp    = ERR_CP;
        w_emit_err   = 1'b0;
        w_emit_trunc = 1'b0;
        w_emit_last  = 1'b0;
        w_hold_set   = 1'b0;
        if (w_go) begin
            if (r_state == ST_IDLE) begin
                w_emit_last = w_last;
                if (w_lead.invalid) begin
                    w_emit     = 1'b1;
                    w_emit_err = 1'b1;
                end else if (w_lead.len == 3'd1) begin
                    w_emit    = 1'b1;
                    w_emit_cp = {13'd0, w_byte};
                end else if (w_last) begin
                    w_emit       = 1'b1;
                    w_emit_err   = 1'b1;
                    w_emit_trunc = 1'b1;
                end else begin
                    w_lo_nxt = w_lead.lo;
                    w_hi_nxt = w_lead.hi;
                    case (w_lead.len)
                        3'd2:    begin w_state_nxt = ST_C1; w_acc_nxt = {10'd0, w_byte[4:0]}; end
                        3'd3:    begin w_state_nxt = ST_C2; w_acc_nxt = {11'd0, w_byte[3:0]}; end
                        default: begin w_state_nxt = ST_C3; w_acc_nxt = {12'd0, w_byte[2:0]}; end
                    endcase
                end
            end else if (w_in_range) begin
                w_acc_nxt = w_cp_full[14:0];
                w_lo_nxt  = 8'h80;
                w_hi_nxt  = 8'hBF;
                if (r_state == ST_C1) begin
                    w_state_nxt = ST_IDLE;
                    w_emit      = 1'b1;
                    w_emit_last = w_last;
                    if (w_cp_legal) w_emit_cp  = w_cp_full;
                    else            w_emit_err = 1'b1;
                end else if (w_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_emit       = 1'b1;
                    w_emit_err   = 1'b1;
                    w_emit_trunc = 1'b1;
                    w_emit_last  = 1'b1;
                end else begin
                    w_state_nxt = (r_state == ST_C3) ? ST_C2 : ST_C1;
                end
            end else begin
                // Offending byte is parked and re-decoded as a lead next free cycle.
                w_state_nxt = ST_IDLE;
                w_emit      = 1'b1;
                w_emit_err  = 1'b1;
                w_hold_set  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_lo        <= 8'h80;
            r_hi        <= 8'hBF;
            r_hold_v    <= 1'b0;
            r_hold_byte <= '0;
            r_hold_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            if (w_hold_set) begin
                r_hold_v    <= 1'b1;
                r_hold_byte <= w_byte;
                r_hold_last <= w_last;
            end else if (w_go) begin
                r_hold_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_out_valid <= 1'b0;
            r_out_cp    <= '0;
            r_out_err   <= 1'b0;
            r_out_trunc <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_go && w_emit) begin
                r_out_valid <= 1'b1;
                r_out_cp    <= w_emit_cp;
                r_out_err   <= w_emit_err;
                r_out_trunc <= w_emit_trunc;
                r_out_last  <= w_emit_last;
                if (w_emit_err && (r_err_count != {CNT_W{1'b1}}))
                    r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_cp    = r_out_cp;
    assign out_err   = r_out_err;
    assign out_trunc = r_out_trunc;
    assign out_last  = r_out_last;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Scoreboard bench: expected tokens queued when bytes are driven, popped on each output transfer.
module tb_utf8_stream_decoder;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  d1_data = 8'h00;
    logic        d1_valid = 1'b0, d1_last = 1'b0, d1_or = 1'b1;
    logic        d1_ready, d1_ov, d1_err, d1_trunc, d1_olast;
    logic [20:0] d1_cp;
    logic [15:0] d1_cnt;

    logic [7:0]  d2_data = 8'h00;
    logic        d2_valid = 1'b0, d2_last = 1'b0, d2_or = 1'b1;
    logic        d2_ready, d2_ov, d2_err, d2_trunc, d2_olast;
    logic [20:0] d2_cp;
    logic [1:0]  d2_cnt;

    utf8_stream_decoder #(.REPLACE(1'b1), .ALLOW_SURR(1'b0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_in(rst_in), .in_data(d1_data), .in_valid(d1_valid), .in_last(d1_last),
        .in_ready(d1_ready), .out_cp(d1_cp), .out_valid(d1_ov), .out_ready(d1_or),
        .out_err(d1_err), .out_trunc(d1_trunc), .out_last(d1_olast), .err_count(d1_cnt)
    );

    utf8_stream_decoder #(.REPLACE(1'b0), .ALLOW_SURR(1'b1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_in(rst_in), .in_data(d2_data), .in_valid(d2_valid), .in_last(d2_last),
        .in_ready(d2_ready), .out_cp(d2_cp), .out_valid(d2_ov), .out_ready(d2_or),
        .out_err(d2_err), .out_trunc(d2_trunc), .out_last(d2_olast), .err_count(d2_cnt)
    );

    typedef struct packed {
        logic [20:0] cp;
        logic        err;
        logic        trunc;
        logic        last;
    } tok_t;

    tok_t q1[$];
    tok_t q2[$];
    tok_t t1, t2;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic tok_t mk(input logic [20:0] cp, input logic err, input logic trunc,
                                input logic last);
        tok_t t;
        t.cp = cp; t.err = err; t.trunc = trunc; t.last = last;
        return t;
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_in && d1_ov && d1_or) begin
            if (q1.size() == 0) chk("u1_unexpected_token", q1.size(), 1);
            else begin
                t1 = q1.pop_front();
                chk("u1_cp",    32'(d1_cp),    32'(t1.cp));
                chk("u1_err",   32'(d1_err),   32'(t1.err));
                chk("u1_trunc", 32'(d1_trunc), 32'(t1.trunc));
                chk("u1_last",  32'(d1_olast), 32'(t1.last));
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_in && d2_ov && d2_or) begin
            if (q2.size() == 0) chk("u2_unexpected_token", q2.size(), 1);
            else begin
                t2 = q2.pop_front();
                chk("u2_cp",    32'(d2_cp),    32'(t2.cp));
                chk("u2_err",   32'(d2_err),   32'(t2.err));
                chk("u2_trunc", 32'(d2_trunc), 32'(t2.trunc));
                chk("u2_last",  32'(d2_olast), 32'(t2.last));
            end
        end
    end

    task automatic send(input int u, input logic [7:0] b, input logic l);
        int n = 0;
        @(negedge clk);
        if (u == 1) begin d1_data = b; d1_last = l; d1_valid = 1'b1; end
        else        begin d2_data = b; d2_last = l; d2_valid = 1'b1; end
        #1;
        while ((((u == 1) ? d1_ready : d2_ready) !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        if (u == 1) begin d1_valid = 1'b0; d1_last = 1'b0; end
        else        begin d2_valid = 1'b0; d2_last = 1'b0; end
    endtask

    task automatic drain(input int u);
        int n = 0;
        while ((((u == 1) ? q1.size() : q2.size()) != 0) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        chk((u == 1) ? "u1_drain" : "u2_drain", (u == 1) ? q1.size() : q2.size(), 0);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 32'(d1_ov),    0);
        chk("rst_out_cp",    32'(d1_cp),    0);
        chk("rst_out_err",   32'(d1_err),   0);
        chk("rst_out_trunc", 32'(d1_trunc), 0);
        chk("rst_out_last",  32'(d1_olast), 0);
        chk("rst_err_count", 32'(d1_cnt),   0);
        chk("rst_in_ready",  32'(d1_ready), 1);
        @(negedge clk);
        rst_in = 1'b1;

        // 3-byte char with last, then a 2-byte char and ASCII
        q1.push_back(mk(21'h020AC, 1'b0, 1'b0, 1'b1));
        send(1, 8'hE2, 1'b0); send(1, 8'h82, 1'b0);
        chk("pre_lat_valid", 32'(d1_ov), 0);
        send(1, 8'hAC, 1'b1);
        @(negedge clk); #1;
        chk("lat_valid", 32'(d1_ov), 1);
        q1.push_back(mk(21'h000E9, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(21'h00041, 1'b0, 1'b0, 1'b0));
        send(1, 8'hC3, 1'b0); send(1, 8'hA9, 1'b0); send(1, 8'h41, 1'b0);
        drain(1);
        chk("cnt_after_valid", 32'(d1_cnt), 0);

        // invalid leads
        q1.push_back(mk(21'h0FFFD, 1'b1, 1'b0, 1'b0));
        q1.push_back(mk(21'h0FFFD, 1'b1, 1'b0, 1'b0));
        send(1, 8'hC0, 1'b0); send(1, 8'hAF, 1'b0);
        drain(1);
        chk("cnt_c0af", 32'(d1_cnt), 2);

        // surrogate rejected: ED A0 80 -> three errors
        for (int i = 0; i < 3; i++) q1.push_back(mk(21'h0FFFD, 1'b1, 1'b0, 1'b0));
        send(1, 8'hED, 1'b0); send(1, 8'hA0, 1'b0); send(1, 8'h80, 1'b0);
        drain(1);

        // mismatch with re-decode and one-cycle in_ready bubble
        q1.push_back(mk(21'h0FFFD, 1'b1, 1'b0, 1'b0));
        q1.push_back(mk(21'h00041, 1'b0, 1'b0, 1'b0));
        send(1, 8'hE2, 1'b0); send(1, 8'h82, 1'b0); send(1, 8'h41, 1'b0);
        @(negedge clk); #1;
        chk("bubble_low", 32'(d1_ready), 0);
        @(negedge clk); #1;
        chk("bubble_high", 32'(d1_ready), 1);
        drain(1);

        // truncation, then F4 above-range
        q1.push_back(mk(21'h0FFFD, 1'b1, 1'b1, 1'b1));
        send(1, 8'hF0, 1'b0); send(1, 8'h9F, 1'b1);
        for (int i = 0; i < 4; i++) q1.push_back(mk(21'h0FFFD, 1'b1, 1'b0, 1'b0));
        send(1, 8'hF4, 1'b0); send(1, 8'h90, 1'b0); send(1, 8'h80, 1'b0); send(1, 8'h80, 1'b0);
        drain(1);
        chk("cnt_total", 32'(d1_cnt), 11);

        // backpressure stall on a 4-byte char
        d1_or = 1'b0;
        q1.push_back(mk(21'h1F600, 1'b0, 1'b0, 1'b0));
        send(1, 8'hF0, 1'b0); send(1, 8'h9F, 1'b0); send(1, 8'h98, 1'b0); send(1, 8'h80, 1'b0);
        d1_valid = 1'b1; d1_data = 8'h41;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", 32'(d1_ov),    1);
            chk("stall_cp",    32'(d1_cp),    32'h1F600);
            chk("stall_ready", 32'(d1_ready), 0);
        end
        d1_valid = 1'b0;
        @(negedge clk);
        d1_or = 1'b1;
        drain(1);

        // second instance: surrogates allowed, zero-valued errors, 2-bit counter saturation
        q2.push_back(mk(21'h0D800, 1'b0, 1'b0, 1'b0));
        send(2, 8'hED, 1'b0); send(2, 8'hA0, 1'b0); send(2, 8'h80, 1'b0);
        drain(2);
        chk("u2_cnt_surr", 32'(d2_cnt), 0);
        for (int i = 0; i < 4; i++) q2.push_back(mk(21'h0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) send(2, 8'hFF, 1'b0);
        drain(2);
        chk("u2_cnt_sat", 32'(d2_cnt), 3);

        // async reset mid-sequence discards the partial character
        send(1, 8'hF0, 1'b0); send(1, 8'h9F, 1'b0);
        @(negedge clk); #3;
        rst_in = 1'b0;
        #1;
        chk("arst_cnt", 32'(d1_cnt), 0);
        @(negedge clk); #3;
        rst_in = 1'b1;
        q1.push_back(mk(21'h0FFFD, 1'b1, 1'b0, 1'b1));
        send(1, 8'h80, 1'b1);
        drain(1);

        // async reset with a token stalled and a byte parked in the hold register
        d1_or = 1'b0;
        send(1, 8'hE2, 1'b0); send(1, 8'h41, 1'b0);
        @(negedge clk); #1;
        chk("pre_arst_valid", 32'(d1_ov), 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_valid", 32'(d1_ov),  0);
        chk("arst_cnt2",  32'(d1_cnt), 0);
        @(negedge clk); #3;
        rst_in = 1'b1;
        d1_or = 1'b1;
        q1.push_back(mk(21'h00042, 1'b0, 1'b0, 1'b1));
        send(1, 8'h42, 1'b1);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/utf8_stream_decoder.md
Name: utf8_stream_decoder

Overview:
Streaming strict UTF-8 (RFC 3629) decoder with valid/ready handshakes on both sides. It accepts one byte per cycle and emits one 21-bit Unicode scalar value per completed character. Malformed input is reported as one error token per maximal ill-formed subpart. It sits downstream of byte-oriented I/O and feeds code-point consumers that cannot tolerate the permissive 1–6 byte, 31-bit forms handled by hardware_utf8.

Parameters:
REPLACE, 1, error tokens carry U+FFFD in out_cp when 1; carry 0 when 0
ALLOW_SURR, 0, when 1, ED A0–BF is accepted and surrogates D800–DFFF are emitted as normal scalars
CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-low; clears all state
in_data  in  8  input byte
in_valid  in  1  in_data valid
in_last  in  1  byte is the final byte of the stream
in_ready  out  1  decoder accepts in_data this cycle
out_cp  out  21  decoded code point, or the error token value
out_valid  out  1  out_cp valid
out_ready  in  1  consumer accepts out_cp
out_err  out  1  token is an error (ill-formed subpart)
out_trunc  out  1  error caused by end-of-stream inside a sequence
out_last  out  1  final token of the stream
err_count  out  CNT_W  error tokens emitted since reset; saturates at all-ones

Behaviour:
- Reset: out_valid=0, out_cp=0, out_err=0, out_trunc=0, out_last=0, err_count=0, FSM=IDLE, hold register empty. in_ready=1 after reset.
- Transfer: occurs on a cycle with valid&ready, on each side independently.
- Output register (1 entry): free = !out_valid | out_ready.
- Ready rule: in_ready = free & !hold_v. in_ready is independent of in_data.
- Hold register: hold_v and hold_byte, plus the last flag. When hold_v=1, the held byte is processed in place of the input that cycle, provided the output register is free.
- FSM states: IDLE, C1, C2, C3 (continuation bytes still required). Registers: acc[20:0], lo/hi bound for the next continuation byte, prefix-length count.
- Lead bytes in IDLE:
  - 00–7F: emit the byte immediately.
  - C2–DF: go to C1, bounds 80–BF.
  - E0: go to C2, bounds A0–BF.
  - E1–EC and EE–EF: go to C2, bounds 80–BF.
  - ED: go to C2, bounds 80–9F (80–BF if ALLOW_SURR=1).
  - F0: go to C3, bounds 90–BF.
  - F1–F3: go to C3, bounds 80–BF.
  - F4: go to C3, bounds 80–8F.
  - 80–BF, C0, C1, F5–FF: emit one error token, stay in IDLE.
- Continuation bytes: after the first continuation, bounds reset to 80–BF.
  - In range: acc = {acc, byte[5:0]}. The count decrements; at zero, emit acc and return to IDLE.
  - Out of range: emit one error token for the prefix accumulated so far, return to IDLE, and capture the byte into the hold register. It is re-decoded as a lead byte the next cycle the output register is free.
- Latency: out_valid rises the cycle after the final byte (or offending byte) is accepted. Sustained throughput is 1 byte per cycle with out_ready=1. One bubble on in_ready per mismatch.
- in_last handling:
  - If in_last is on a byte that completes a character or error token, out_last=1 on that token.
  - If in_last is on a lead byte or a non-final continuation, emit one error token with out_trunc=1 and out_last=1, and return to IDLE.
  - If in_last is on a mismatching byte, the prefix error has out_last=0. The last flag travels with the held byte.
- Backpressure: the token stays stable while out_valid & !out_ready. No byte is accepted while the output register is full, and the FSM holds.
- err_count increments on each error-token transfer into the output register, saturating at the maximum.
- Async reset mid-sequence: the partial sequence is discarded and no token is emitted.

Decomposition:
- Shared package utf8_pkg:
  - constants CP_REPLACEMENT=21'h00FFFD, CP_MAX=21'h10FFFF, SURR_LO=21'h00D800, SURR_HI=21'h00DFFF
  - FSM state enum
  - lead-byte class function returning {len, lo, hi, invalid}
- One sub-module, utf8_lead_classify: combinational lead-byte table, reused by the decoder and a future stream validator.

Test Plan:
- E2 82 AC, in_last on AC, out_ready=1 -> one token cp=0x20AC, out_err=0, out_last=1, valid one cycle after AC accepted; err_count=0.
- C0 AF -> two tokens, cp=0xFFFD each, out_err=1; err_count=2.
- ED A0 80 with ALLOW_SURR=0 -> three error tokens (ED, A0, 80). With ALLOW_SURR=1 -> one token cp=0xD800.
- E2 82 41 -> error token cp=0xFFFD, then cp=0x41; in_ready low exactly one cycle after 41 accepted.
- F0 9F with in_last on 9F -> one token, out_err=1, out_trunc=1, out_last=1. Then F4 90 80 80 -> four error tokens.
- F0 9F 98 80 with out_ready held 0 for 5 cycles after out_valid -> cp=0x1F600 held stable. in_ready=0 during the stall. Asserting rst_in low mid-sequence clears out_valid and err_count asynchronously.
